ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Multi-cycle HI/LO multiply/divide unit for the EX stage; replaces single-cycle combinational MULT/DIV.
//  Generalised to WIDTH bits; pipelined multiply with MUL_LAT latency; radix-2 iterative divide.
//  Raises stallreq while busy. Cancels on pipeline flush. Returns a one-cycle done pulse with the hi/lo result.
// PARAMETERS
//  WIDTH    32  operand width; hi_o/lo_o are WIDTH each, product is 2*WIDTH
//  MUL_LAT  2   cycles from start to done for multiply ops (1..4)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, asynchronous, active-high
//  start         in   1      op request; sampled only in IDLE
//  op            in   3      MULDIV_OP_* encoding (consts.v)
//  opa, opb      in   WIDTH  rs/rt operands, sampled with start
//  acc_hi,acc_lo in   WIDTH  forwarded HI/LO, sampled with start (MADD family only)
//  cancel        in   1      flush; aborts the current op
//  stallreq      out  1      combinational: start&legal_op in IDLE, or state MUL/DIV
//  busy          out  1      registered: state != IDLE
//  done          out  1      one-cycle pulse; hi_o/lo_o valid in this cycle
//  hi_o, lo_o    out  WIDTH  result; holds until the next done
//  div_by_zero   out  1      valid with done; 1 when divisor==0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, div_by_zero, hi_o, lo_o, counters, datapath regs = 0. Applies immediately mid-op.
//  FSM IDLE->MUL|DIV on start&legal; MUL->DONE after MUL_LAT-1 cycles; DIV->DONE after WIDTH iterations; DONE->IDLE.
//  Latency: done rises MUL_LAT cycles (mult) or WIDTH+1 cycles (div) after the start cycle.
//  stallreq is low in DONE, so EX advances together with the result.
//  start while busy: ignored. Illegal op in IDLE: ignored, no busy, no stall.
//  cancel in MUL/DIV/DONE: next state IDLE, no done, hi_o/lo_o unchanged. cancel+start in IDLE: cancel wins.
//  MULT: signed 2*WIDTH product. MULTU: unsigned. {hi_o,lo_o} = product.
//  DIV/DIVU: restoring radix-2 on magnitudes, one quotient bit per cycle. lo_o=quotient, hi_o=remainder.
//   Signed rules: quotient negated if signs differ; remainder takes the dividend's sign.
//   MIN_INT/-1 wraps: lo=MIN_INT, hi=0.
//  divisor==0: skip iterations, DIV->DONE next cycle (done at start+2).
//   Result lo_o=all ones, hi_o=opa, div_by_zero=1.
//  All arithmetic wraps modulo 2^(2*WIDTH).
// CONFIGURATION
//  EX_MULDIV_MADD_EN defined:
//   MADD/MADDU: {hi,lo} = {acc_hi,acc_lo} + product.
//   MSUB/MSUBU: {hi,lo} = {acc_hi,acc_lo} - product.
//   Latency MUL_LAT+1.
//  Undefined: these four opcodes are illegal and ignored as above.
// STRUCTURE
//  consts.v: MULDIV_OP_{MULT,MULTU,DIV,DIVU,MADD,MADDU,MSUB,MSUBU} encodings and FSM state encodings.
//  Sub-module ex_div_core: magnitude restoring divider with load/step/cancel and an iteration counter.
//  Top level owns sign fix-up, the multiply delay line and the FSM.
// TESTING (WIDTH=32, MUL_LAT=2)
//  MULT FFFFFFFD*00000007 -> done at +2, hi=FFFFFFFF lo=FFFFFFEB, stallreq high for cycles 0-1.
//  MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//  DIV FFFFFFF9/00000002 -> done at +33, lo=FFFFFFFD hi=FFFFFFFF.
//  DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  DIVU 5/0 -> done at +2, div_by_zero=1, lo=FFFFFFFF hi=00000005.
//  DIVU started, cancel at +10 -> no done, busy low at +11, new MULT at +11 completes normally.
//  Also check: hi_o/lo_o keep their prior values after the cancel.
//  rst pulse mid-DIV -> busy/stallreq/outputs 0 immediately, no done after release.
//  MADD_EN: acc {0,1}, MADD 2*3 -> lo=7 hi=0. Without the macro: MADD start -> busy stays 0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// operation encodings, FSM state encoding and small opcode decoders.
package ex_muldiv_pkg;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_MADD  = 3'd4;
  localparam logic [2:0] MULDIV_OP_MADDU = 3'd5;
  localparam logic [2:0] MULDIV_OP_MSUB  = 3'd6;
  localparam logic [2:0] MULDIV_OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == MULDIV_OP_DIV) || (o == MULDIV_OP_DIVU);
  endfunction

  // Signed flavours: MULT, DIV, MADD, MSUB (even encodings).
  function automatic logic op_is_signed(input logic [2:0] o);
    return ~o[0];
  endfunction

  // Accumulating flavours: MADD/MADDU/MSUB/MSUBU.
  function automatic logic op_is_madd(input logic [2:0] o);
    return o[2];
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Magnitude restoring radix-2 divider. load_i captures dividend/divisor,
// each step_i cycle produces one quotient bit (MSB first); last_o flags
// the step that produces the final bit. cancel_i clears the iteration count.
module ex_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    trial  = {rem_q, quot_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    if (cancel_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      // diff[WIDTH] is the borrow: set when the trial value is below the divisor
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// Multiply goes through a MUL_LAT-deep delay line; divide uses ex_div_core
// on magnitudes with sign fix-up here. Optional MADD/MADDU/MSUB/MSUBU
// support is enabled by defining EX_MULDIV_MADD_EN.
// Handshake: a request is accepted when start is high with a legal op while
// IDLE and cancel is low; done pulses for one cycle with hi_o/lo_o valid,
// and stallreq holds the pipeline from the accept cycle until DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic          cancel,
  output logic          stallreq,
  output logic          busy,
  output logic          done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic          div_by_zero,
  output muldiv_state_t state_o
);

  localparam int PW        = 2 * WIDTH;
  localparam int PIPE_N    = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int PIPE_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  muldiv_state_t    state_q, state_d;
  logic             op_legal;
  logic             accept;
  logic [2:0]       op_q;
  logic [2:0]       mcnt_q;
  logic [PW-1:0]    mul_a_q, mul_b_q, acc_q;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    mul_res;
  logic [PW-1:0]    pipe_q [PIPE_N];
  logic [WIDTH-1:0] opa_q;
  logic             neg_q_q, neg_r_q, dz_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             in_signed;
  logic [WIDTH-1:0] quot, rem;
  logic             div_last;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

`ifdef EX_MULDIV_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~op[2];
`endif

  // Cycles spent in MUL before DONE; the accumulate flavours take one more.
  function automatic int mul_target(input logic [2:0] o);
    return MUL_LAT - 1 + (op_is_madd(o) ? 1 : 0);
  endfunction

  assign accept    = (state_q == ST_IDLE) && start && op_legal && !cancel;
  assign in_signed = op_is_signed(op);
  assign mag_a     = (in_signed && opa[WIDTH-1]) ? -opa : opa;
  assign mag_b     = (in_signed && opb[WIDTH-1]) ? -opb : opb;

  // Next-state logic; cancel returns to IDLE from any active state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_div(op))           state_d = ST_DIV;
          else if (mul_target(op) == 0) state_d = ST_DONE;
          else                          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (cancel) state_d = ST_IDLE;
        else if (int'(mcnt_q) + 1 >= mul_target(op_q)) state_d = ST_DONE;
      end
      ST_DIV: begin
        if (cancel) state_d = ST_IDLE;
        else if (dz_q || div_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and multiply cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                mcnt_q <= '0;
      else if (state_q == ST_MUL) mcnt_q <= mcnt_q + 3'd1;
    end
  end

  // Operand capture at accept; held until the next accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      mul_a_q <= in_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
      mul_b_q <= in_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
      acc_q   <= {acc_hi, acc_lo};
      opa_q   <= opa;
      neg_q_q <= in_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      neg_r_q <= in_signed && opa[WIDTH-1];
      dz_q    <= op_is_div(op) && (opb == '0);
    end
  end

  // Extended operands make one unsigned multiply serve both signednesses.
  assign prod = mul_a_q * mul_b_q;

  // Multiply delay line; operands are held, so the line settles on the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod;
      for (int i = 1; i < PIPE_N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mul_res = (MUL_LAT > 1) ? pipe_q[PIPE_LAST] : prod;

  ex_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && op_is_div(op)),
    .step_i     ((state_q == ST_DIV) && !dz_q),
    .cancel_i   (cancel),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quot_o     (quot),
    .rem_o      (rem),
    .last_o     (div_last)
  );

  assign quot_fix = neg_q_q ? -quot : quot;
  assign rem_fix  = neg_r_q ? -rem  : rem;

  // Result selection for the DONE cycle.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      MULDIV_OP_MULT, MULDIV_OP_MULTU: {res_hi, res_lo} = mul_res;
      MULDIV_OP_MADD, MULDIV_OP_MADDU: {res_hi, res_lo} = acc_q + mul_res;
      MULDIV_OP_MSUB, MULDIV_OP_MSUBU: {res_hi, res_lo} = acc_q - mul_res;
      default: begin
        if (dz_q) {res_hi, res_lo} = {opa_q, {WIDTH{1'b1}}};
        else      {res_hi, res_lo} = {rem_fix, quot_fix};
      end
    endcase
  end

  assign done = (state_q == ST_DONE) && !cancel;

  // Result hold registers, refreshed only by a completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign hi_o        = done ? res_hi : hi_q;
  assign lo_o        = done ? res_lo : lo_q;
  assign div_by_zero = done && dz_q;
  assign busy        = (state_q != ST_IDLE);
  assign stallreq    = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign state_o     = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32, MUL_LAT=2).
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [31:0]   opa, opb, acc_hi, acc_lo;
  logic          cancel;
  logic          stallreq, busy, done, div_by_zero;
  logic [31:0]   hi_o, lo_o;
  muldiv_state_t state_dbg;
  int            n_chk;
  int            n_fail;
  logic [63:0]   exp_q[$];

  ex_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .acc_hi      (acc_hi),
    .acc_lo      (acc_lo),
    .cancel      (cancel),
    .stallreq    (stallreq),
    .busy        (busy),
    .done        (done),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .div_by_zero (div_by_zero),
    .state_o     (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Driver: issue one request, return cycles until done (-1 if none within bound).
  // Operand inputs are cleared after the start cycle to prove they are sampled.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ah, input logic [31:0] al, output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; opa = a; opb = b; acc_hi = ah; acc_lo = al;
    lat = -1;
    @(negedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0; opa = '0; opb = '0; acc_hi = '0; acc_lo = '0;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0;
    opa = '0; opb = '0; acc_hi = '0; acc_lo = '0;
    #2;
    n_chk++;
    if ({busy, done, stallreq, div_by_zero, hi_o, lo_o} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b stall=%b dbz=%b hi=%h lo=%h exp all 0",
               busy, done, stallreq, div_by_zero, hi_o, lo_o);
    end
    n_chk++;
    if (state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, ST_IDLE);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mult;
    @(posedge clk); #1;
    start = 1'b1; op = MULDIV_OP_MULT; opa = 32'hFFFFFFFD; opb = 32'h00000007;
    @(negedge clk);
    n_chk++;
    if ({stallreq, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL mult_c0_flags: got stall/busy/done=%b exp 100", {stallreq, busy, done});
    end
    @(posedge clk); #1;
    start = 1'b0; opa = '0; opb = '0;
    @(negedge clk);
    n_chk++;
    if ({stallreq, busy, done} !== 3'b110) begin
      n_fail++; $display("FAIL mult_c1_flags: got stall/busy/done=%b exp 110", {stallreq, busy, done});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({stallreq, busy, done} !== 3'b011) begin
      n_fail++; $display("FAIL mult_c2_flags: got stall/busy/done=%b exp 011", {stallreq, busy, done});
    end
    n_chk++;
    if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++; $display("FAIL mult_result: got %h_%h exp FFFFFFFF_FFFFFFEB", hi_o, lo_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({busy, done} !== 2'b00 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++; $display("FAIL mult_c3_hold: got busy=%b done=%b %h_%h exp 0 0 FFFFFFFF_FFFFFFEB",
                         busy, done, hi_o, lo_o);
    end
  endtask

  task automatic test_mult_vectors;
    logic [2:0]  t_op [5] = '{MULDIV_OP_MULTU, MULDIV_OP_MULT, MULDIV_OP_MULT,
                              MULDIV_OP_MULTU, MULDIV_OP_MULT};
    logic [31:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] t_b  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    logic [63:0] exp_v;
    int lat;
    exp_q.push_back(64'hFFFFFFFE_00000001);
    exp_q.push_back(64'h00000000_00000001);
    exp_q.push_back(64'h40000000_00000000);
    exp_q.push_back(64'h00000001_00000000);
    exp_q.push_back(64'hFFFFFFFF_80000001);
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 32'h0, 32'h0, lat);
      exp_v = exp_q.pop_front();
      n_chk++;
      if (lat !== 2 || {hi_o, lo_o} !== exp_v || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_vec%0d: got lat=%0d %h_%h dbz=%b exp lat=2 %h dbz=0",
                 i, lat, hi_o, lo_o, div_by_zero, exp_v);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  t_op [6] = '{MULDIV_OP_DIV, MULDIV_OP_DIV, MULDIV_OP_DIVU,
                              MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_DIVU};
    logic [31:0] t_a  [6] = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd7, 32'hFFFFFFFF, 32'd3};
    logic [31:0] t_b  [6] = '{32'h00000002, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd2, 32'd9};
    logic [63:0] t_e  [6] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h00000002_0000000E,
                              64'h00000001_FFFFFFFD, 64'h00000001_7FFFFFFF, 64'h00000003_00000000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 32'h0, 32'h0, lat);
      n_chk++;
      if (lat !== 33 || {hi_o, lo_o} !== t_e[i] || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL div_vec%0d: got lat=%0d %h_%h dbz=%b exp lat=33 %h dbz=0",
                 i, lat, hi_o, lo_o, div_by_zero, t_e[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(MULDIV_OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0, lat);
    n_chk++;
    if (lat !== 2 || div_by_zero !== 1'b1 || {hi_o, lo_o} !== 64'h00000005_FFFFFFFF) begin
      n_fail++; $display("FAIL divu_zero: got lat=%0d dbz=%b %h_%h exp lat=2 dbz=1 00000005_FFFFFFFF",
                         lat, div_by_zero, hi_o, lo_o);
    end
    run_op(MULDIV_OP_DIV, 32'hFFFFFFF0, 32'd0, 32'h0, 32'h0, lat);
    n_chk++;
    if (lat !== 2 || div_by_zero !== 1'b1 || {hi_o, lo_o} !== 64'hFFFFFFF0_FFFFFFFF) begin
      n_fail++; $display("FAIL div_zero_signed: got lat=%0d dbz=%b %h_%h exp lat=2 dbz=1 FFFFFFF0_FFFFFFFF",
                         lat, div_by_zero, hi_o, lo_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL dbz_pulse: got %b after done exp 0", div_by_zero);
    end
  endtask

  task automatic test_cancel;
    int lat;
    int ndone;
    run_op(MULDIV_OP_MULTU, 32'd3, 32'd4, 32'h0, 32'h0, lat);
    ndone = 0;
    // DIVU cancelled at cycle 10
    @(posedge clk); #1;
    start = 1'b1; op = MULDIV_OP_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    // cycle 11: new MULT issued immediately
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b1; op = MULDIV_OP_MULT; opa = 32'd6; opb = 32'd7;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || stallreq !== 1'b1) begin
      n_fail++; $display("FAIL cancel_c11: got busy=%b stall=%b exp busy=0 stall=1", busy, stallreq);
    end
    n_chk++;
    if ({hi_o, lo_o} !== 64'h00000000_0000000C) begin
      n_fail++; $display("FAIL cancel_hold: got %h_%h exp 00000000_0000000C", hi_o, lo_o);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) ndone++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || {hi_o, lo_o} !== 64'h00000000_0000002A) begin
      n_fail++; $display("FAIL cancel_next_mult: got done=%b %h_%h exp done=1 00000000_0000002A",
                         done, hi_o, lo_o);
    end
    n_chk++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL cancel_no_done: got %0d done pulses exp 0", ndone);
    end
    // cancel together with start in IDLE: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = MULDIV_OP_MULT; opa = 32'd9; opb = 32'd9;
    @(negedge clk);
    n_chk++;
    if (stallreq !== 1'b0) begin
      n_fail++; $display("FAIL cancel_start_stall: got %b exp 0", stallreq);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_start_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_start_busy;
    // start held high while the unit is in MUL must be ignored
    @(posedge clk); #1;
    start = 1'b1; op = MULDIV_OP_MULT; opa = 32'd2; opb = 32'd3;
    @(negedge clk);
    @(posedge clk); #1;
    op = MULDIV_OP_MULTU; opa = 32'd10; opb = 32'd10;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || {hi_o, lo_o} !== 64'd6) begin
      n_fail++; $display("FAIL start_busy: got done=%b %h_%h exp done=1 00000000_00000006", done, hi_o, lo_o);
    end
  endtask

  task automatic test_madd;
    int lat;
`ifdef EX_MULDIV_MADD_EN
    run_op(MULDIV_OP_MADD, 32'd2, 32'd3, 32'd0, 32'd1, lat);
    n_chk++;
    if (lat !== 3 || {hi_o, lo_o} !== 64'd7) begin
      n_fail++; $display("FAIL madd: got lat=%0d %h_%h exp lat=3 00000000_00000007", lat, hi_o, lo_o);
    end
    run_op(MULDIV_OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, lat);
    n_chk++;
    if (lat !== 3 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) begin
      n_fail++; $display("FAIL msubu: got lat=%0d %h_%h exp lat=3 FFFFFFFF_FFFFFFFF", lat, hi_o, lo_o);
    end
`else
    lat = 0;
    @(posedge clk); #1;
    start = 1'b1; op = MULDIV_OP_MADD; opa = 32'd2; opb = 32'd3; acc_hi = 32'd0; acc_lo = 32'd1;
    @(negedge clk);
    n_chk++;
    if (stallreq !== 1'b0) begin
      n_fail++; $display("FAIL madd_illegal_stall: got %b exp 0", stallreq);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) lat++;
    end
    n_chk++;
    if (lat !== 0) begin
      n_fail++; $display("FAIL madd_illegal_busy: got %0d busy/done cycles exp 0", lat);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; op = MULDIV_OP_DIVU; opa = 32'd100; opb = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, stallreq, done, div_by_zero, hi_o, lo_o} !== 68'd0 || state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b stall=%b done=%b dbz=%b %h_%h exp all 0",
                         busy, stallreq, done, div_by_zero, hi_o, lo_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL reset_mid_after: got %0d busy/done cycles exp 0", ndone);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_mult();
    test_mult_vectors();
    test_div();
    test_div_zero();
    test_cancel();
    test_start_busy();
    test_madd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
